// File: rtl/button_pulse_gen_if.sv
// Button/toggle bus between board pins and the pulse generator.
// master drives raw inputs; slave (the generator) drives pulse, switch and held.
interface button_pulse_gen_if;
  logic       button_raw;
  logic [3:0] toggle_raw;
  logic       button_pulse;
  logic [3:0] toggle_switch;
  logic       held;

  modport master (
    output button_raw,
    output toggle_raw,
    input  button_pulse,
    input  toggle_switch,
    input  held
  );

  modport slave (
    input  button_raw,
    input  toggle_raw,
    output button_pulse,
    output toggle_switch,
    output held
  );
endinterface

// File: rtl/button_pulse_gen.sv
// Debounced push-button strobe generator; latches toggle switches per strobe.
// Ports: clk, rst (async, high), bus (slave: raw in; pulse/switch/held out).
// Define BUTTON_AUTOREPEAT_EN to compile in auto-repeat while held.
module button_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 1000,
  parameter int unsigned REPEAT_PERIOD   = 250
) (
  input  logic clk,
  input  logic rst,
  button_pulse_gen_if.slave bus
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535)
    $error("DEBOUNCE_CYCLES out of range");
  if (REPEAT_DELAY < 2 || REPEAT_DELAY > 65535)
    $error("REPEAT_DELAY out of range");
  if (REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535)
    $error("REPEAT_PERIOD out of range");

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic       r_btn_s1;
  logic       r_btn_s2;
  logic [3:0] r_tog_s1;
  logic [3:0] r_tog_s2;
  state_t     r_state;
  logic [15:0] r_cnt;
  logic       r_pulse;
  logic [3:0] r_toggle;
  logic       r_held;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [15:0] RD_LAST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] RP_LAST = 16'(REPEAT_PERIOD - 1);
  // Set once the first repeat fired; later repeats use the period.
  logic        r_rep;
  logic [15:0] w_rep_last;
  assign w_rep_last = r_rep ? RP_LAST : RD_LAST;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_tog_s1 <= 4'b0000;
      r_tog_s2 <= 4'b0000;
      r_state  <= IDLE;
      r_cnt    <= 16'd0;
      r_pulse  <= 1'b0;
      r_toggle <= 4'b0000;
      r_held   <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      r_rep    <= 1'b0;
`endif
    end else begin
      r_btn_s1 <= bus.button_raw;
      r_btn_s2 <= r_btn_s1;
      r_tog_s1 <= bus.toggle_raw;
      r_tog_s2 <= r_tog_s1;
      r_pulse  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_btn_s2) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= 16'd0;
          end
        end
        PRESS_WAIT: begin
          if (!r_btn_s2) begin
            r_state <= IDLE;
          end else if (r_cnt == DB_LAST) begin
            r_state  <= HELD;
            r_cnt    <= 16'd0;
            r_pulse  <= 1'b1;
            r_toggle <= r_tog_s2;
            r_held   <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
            r_rep    <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        HELD: begin
          if (!r_btn_s2) begin
            r_state <= REL_WAIT;
            r_cnt   <= 16'd0;
          end else begin
`ifdef BUTTON_AUTOREPEAT_EN
            if (r_cnt == w_rep_last) begin
              r_pulse  <= 1'b1;
              r_toggle <= r_tog_s2;
              r_cnt    <= 16'd0;
              r_rep    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
`endif
          end
        end
        REL_WAIT: begin
          // Bounce back to pressed: no new strobe, repeat timing restarts.
          if (r_btn_s2) begin
            r_state <= HELD;
            r_cnt   <= 16'd0;
`ifdef BUTTON_AUTOREPEAT_EN
            r_rep   <= 1'b0;
`endif
          end else if (r_cnt == DB_LAST) begin
            r_state <= IDLE;
            r_held  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.button_pulse  = r_pulse;
  assign bus.toggle_switch = r_toggle;
  assign bus.held          = r_held;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Random + directed bench for button_pulse_gen against a run-length model.
// Model counts consecutive synchronized samples rather than FSM states.
module tb_button_pulse_gen;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst;
  button_pulse_gen_if bus();

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // reference model state
  logic       m_b1, m_b2;
  logic [3:0] m_t1, m_t2;
  bit         pressed;
  int         run1, run0, hold;
  bit         rep;
  bit         m_pulse;
  logic [3:0] m_tog;
  bit         prev_pulse;
  int         n_edge;
  int         first_pulse_edge;
  int         n_pulses;

  task automatic model_reset();
    m_b1 = 0; m_b2 = 0; m_t1 = '0; m_t2 = '0;
    pressed = 0; run1 = 0; run0 = 0; hold = 0; rep = 0;
    m_pulse = 0; m_tog = '0; prev_pulse = 0;
    n_edge = 0; first_pulse_edge = -1; n_pulses = 0;
  endtask

  task automatic model_step();
    logic s;
    logic [3:0] ts;
    s = m_b2; ts = m_t2;
    m_b2 = m_b1; m_b1 = bus.button_raw;
    m_t2 = m_t1; m_t1 = bus.toggle_raw;
    m_pulse = 0;
    if (!pressed) begin
      // a press needs D+1 consecutive high samples
      if (s) begin
        run1++;
        if (run1 == D + 1) begin
          pressed = 1; m_pulse = 1; m_tog = ts;
          run1 = 0; run0 = 0; hold = 0; rep = 0;
        end
      end else begin
        run1 = 0;
      end
    end else if (!s) begin
      run0++;
      if (run0 == D + 1) begin
        pressed = 0; run0 = 0; run1 = 0;
      end
    end else if (run0 > 0) begin
      run0 = 0; hold = 0; rep = 0;
    end else begin
`ifdef BUTTON_AUTOREPEAT_EN
      hold++;
      if (hold == (rep ? RP : RD)) begin
        m_pulse = 1; m_tog = ts; hold = 0; rep = 1;
      end
`endif
    end
  endtask

  task automatic cyc(input logic b, input logic [3:0] t);
    bus.button_raw = b;
    bus.toggle_raw = t;
    @(posedge clk);
    model_step();
    n_edge++;
    #1;
    chk("pulse", bus.button_pulse, m_pulse);
    chk("toggle", bus.toggle_switch, m_tog);
    chk("held", bus.held, pressed);
    chk("no_back2back", bus.button_pulse & prev_pulse, 0);
    prev_pulse = bus.button_pulse;
    if (bus.button_pulse) begin
      n_pulses++;
      if (first_pulse_edge < 0) first_pulse_edge = n_edge;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_pulse", bus.button_pulse, 0);
    chk("rst_toggle", bus.toggle_switch, 0);
    chk("rst_held", bus.held, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int len;
    logic b;
    logic [3:0] t;
    rst = 0;
    bus.button_raw = 0;
    bus.toggle_raw = '0;
    model_reset();
    do_reset();

    // clean press
    for (int i = 0; i < 12; i++) cyc(1, 4'b0011);
    chk("latency", first_pulse_edge, D + 3);
    chk("press_tog", bus.toggle_switch, 4'b0011);
    chk("press_held", bus.held, 1);
    for (int i = 0; i < 10; i++) cyc(0, 4'b0011);

    // glitch
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 4'b1111);
    for (int i = 0; i < 10; i++) cyc(0, 4'b1111);
    chk("glitch_pulses", n_pulses, 0);
    chk("glitch_tog", bus.toggle_switch, 0);

    // release bounce
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 4'b0011);
    for (int i = 0; i < 2; i++) cyc(0, 4'b0011);
    for (int i = 0; i < 6; i++) cyc(1, 4'b0100);
    chk("bounce_pulses", n_pulses, 1);
    chk("bounce_tog", bus.toggle_switch, 4'b0011);
    chk("bounce_held", bus.held, 1);

    // reset mid-press, button kept high
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 4'b1010);
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 4'b1010);
    chk("rst_press_lat", first_pulse_edge, D + 3);
    chk("rst_press_cnt", n_pulses, 1);

    // long hold
    do_reset();
    for (int i = 0; i < 100; i++) cyc(1, 4'(i));
`ifdef BUTTON_AUTOREPEAT_EN
    chk("long_hold_cnt", n_pulses, 18);
`else
    chk("long_hold_cnt", n_pulses, 1);
`endif
    for (int i = 0; i < 8; i++) cyc(0, 4'b0);

    // random segments
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      b = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30)
                                        : $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        t = 4'($urandom);
        cyc(b, t);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 want 1");
    $fatal(1);
  end
endmodule

// File: doc/button_pulse_gen.md
BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the cycles raw input must stay stable (legal 2..65535).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 1000, giving the cycles held before the first auto-repeat pulse (legal 2..65535).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 250, giving the cycles between later auto-repeat pulses (legal 2..65535).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 button_raw  input  1  raw push button, asynchronous, active-high.
REQ-007 toggle_raw  input  4  raw toggle switches, asynchronous.
REQ-008 button_pulse  output  1  registered single-cycle press strobe for the game core.
REQ-009 toggle_switch  output  4  registered switch value, stable from each button_pulse until the next.
REQ-010 held  output  1  registered level, high while the debounced button is pressed (HELD or REL_WAIT).

Function
REQ-011 button_raw and toggle_raw SHALL each pass through a 2-flop synchronizer; only the second-stage values (button_s, toggle_s) SHALL be used downstream.
REQ-012 The FSM SHALL have states IDLE, PRESS_WAIT, HELD and REL_WAIT, with one 16-bit counter shared by all states.
REQ-013 IDLE: if button_s=1, go to PRESS_WAIT and clear the counter; otherwise stay.
REQ-014 PRESS_WAIT: if button_s=0, go to IDLE; if the counter equals DEBOUNCE_CYCLES-1, go to HELD, clear the counter and register button_pulse=1; otherwise increment the counter.
REQ-015 HELD: if button_s=0, go to REL_WAIT and clear the counter.
REQ-016 REL_WAIT: if button_s=1, return to HELD with no new pulse; if the counter equals DEBOUNCE_CYCLES-1, go to IDLE; otherwise increment the counter.
REQ-017 Latency: with button_raw high from sampling edge 1 onward, button_pulse SHALL be high for exactly the one cycle following edge DEBOUNCE_CYCLES+3.
REQ-018 On every edge that registers button_pulse=1, toggle_switch SHALL load toggle_s; at all other edges it SHALL hold its value.
REQ-019 A glitch on button_raw shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse and SHALL leave toggle_switch unchanged.
REQ-020 Without auto-repeat, the block SHALL produce exactly one pulse per debounced press, however long the button is held.
REQ-021 button_pulse SHALL never be high on two consecutive cycles.

Reset
REQ-022 rst=1 SHALL immediately clear, without waiting for a clock edge: button_pulse=0, toggle_switch=4'b0000, held=0, both synchronizers=0, counter=0, state=IDLE.
REQ-023 Reset mid-operation SHALL abandon any in-progress debounce or repeat with no pulse.
REQ-024 If the button is still pressed after rst deasserts, it SHALL be treated as a new press and pulse after the full REQ-017 latency.

Configuration
REQ-025 Macro BUTTON_AUTOREPEAT_EN SHALL compile in auto-repeat; without it, the repeat logic SHALL be absent and REQ-020 SHALL apply.
REQ-026 With BUTTON_AUTOREPEAT_EN, in HELD the counter SHALL increment every cycle; at count REPEAT_DELAY-1, register button_pulse=1, load toggle_switch and clear the counter.
REQ-027 With BUTTON_AUTOREPEAT_EN, every later repeat pulse SHALL occur at count REPEAT_PERIOD-1, again loading toggle_switch and clearing the counter.
REQ-028 With BUTTON_AUTOREPEAT_EN, a return from REL_WAIT to HELD SHALL restart the REPEAT_DELAY phase.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-029 Clean press: toggle_raw=4'b0011, button_raw high from edge 1 -> one button_pulse in the cycle after edge 7, toggle_switch=4'b0011 from then, held=1.
REQ-030 Glitch: button_raw high for 3 cycles then low -> button_pulse stays 0, toggle_switch stays 4'b0000, held stays 0.
REQ-031 Release bounce: while HELD, button_raw low 2 cycles then high, with toggle_raw changed to 4'b0100 -> no pulse, held stays 1, toggle_switch unchanged.
REQ-032 Reset mid-press: rst pulsed while PRESS_WAIT count=2, button kept high -> outputs 0 at once; one pulse 7 edges after rst deasserts.
REQ-033 Long hold, macro off: button held 100 cycles -> exactly one pulse.
REQ-034 Long hold, macro on: button held 100 cycles -> pulses 10 cycles after the first pulse, then every 5 cycles; never on two consecutive cycles.
